// File: rtl/dith_gen_if.sv
// rtl/dith_gen_if.sv - dither generator control inputs and modulation/trigger outputs
interface dith_gen_if #(
    parameter int W    = 16,
    parameter int HP_W = 24
);
    logic                   dithEN;
    logic [HP_W-1:0]        half_period;
    logic signed [W-1:0]    amp;
    logic signed [W-1:0]    mod_out;
    logic                   ref_out;
    logic                   trig;
    logic                   active;
    logic [31:0]            cyc_cnt;

    modport master (
        output dithEN, half_period, amp,
        input  mod_out, ref_out, trig, active, cyc_cnt
    );

    modport slave (
        input  dithEN, half_period, amp,
        output mod_out, ref_out, trig, active, cyc_cnt
    );
endinterface

// File: rtl/dith_gen.sv
// rtl/dith_gen.sv - square-wave dither generator with whole-cycle enable gating
module dith_gen #(
    parameter int W    = 16,
    parameter int HP_W = 24
) (
    input  logic      clk,
    input  logic      rst_n,
    dith_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, POS, NEG} state_t;

    localparam logic [HP_W-1:0]     HP_ONE = {{(HP_W-1){1'b0}}, 1'b1};
    localparam logic signed [W-1:0] MIN_V  = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_V  = {1'b0, {(W-1){1'b1}}};

    state_t                 state_q, state_d;
    logic [HP_W-1:0]        cnt_q, cnt_d;
    logic [HP_W-1:0]        hp_q, hp_d;
    logic signed [W-1:0]    amp_q, amp_d;
    logic signed [W-1:0]    mod_q, mod_d;
    logic                   ref_q, ref_d;
    logic                   trig_q, trig_d;
    logic                   active_q, active_d;
    logic [31:0]            cyc_cnt_q, cyc_cnt_d;
    logic [HP_W-1:0]        hp_in;
    logic                   half_done;

    // Saturating negation so the most negative amplitude maps to the most positive.
    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] x);
        if (x == MIN_V) begin
            return MAX_V;
        end
        return -x;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        amp_d     = amp_q;
        trig_d    = 1'b0;
        cyc_cnt_d = cyc_cnt_q;
        hp_in     = (bus.half_period == '0) ? HP_ONE : bus.half_period;
        half_done = (cnt_q == hp_q - HP_ONE);

        case (state_q)
            IDLE: begin
                if (bus.dithEN) begin
                    hp_d    = hp_in;
                    amp_d   = bus.amp;
                    cnt_d   = '0;
                    state_d = POS;
                end
            end
            POS: begin
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = NEG;
                end else begin
                    cnt_d = cnt_q + HP_ONE;
                end
            end
            NEG: begin
                if (half_done) begin
                    cnt_d     = '0;
                    trig_d    = 1'b1;
                    cyc_cnt_d = cyc_cnt_q + 32'd1;
                    if (bus.dithEN) begin
                        hp_d    = hp_in;
                        amp_d   = bus.amp;
                        state_d = POS;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + HP_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        mod_d    = '0;
        ref_d    = 1'b0;
        active_d = 1'b0;
        case (state_d)
            POS: begin
                mod_d    = amp_d;
                ref_d    = 1'b1;
                active_d = 1'b1;
            end
            NEG: begin
                mod_d    = sat_neg(amp_d);
                active_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hp_q      <= HP_ONE;
            amp_q     <= '0;
            mod_q     <= '0;
            ref_q     <= 1'b0;
            trig_q    <= 1'b0;
            active_q  <= 1'b0;
            cyc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            amp_q     <= amp_d;
            mod_q     <= mod_d;
            ref_q     <= ref_d;
            trig_q    <= trig_d;
            active_q  <= active_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    assign bus.mod_out = mod_q;
    assign bus.ref_out = ref_q;
    assign bus.trig    = trig_q;
    assign bus.active  = active_q;
    assign bus.cyc_cnt = cyc_cnt_q;
endmodule
